// File: rtl/rou_msg_parse.sv
// roubus receive side: 2-entry message FIFO, field split, per-cmd dispatch
// and an outstanding-read tag scoreboard with error pulses and counter.
module rou_msg_parse #(
    parameter int DWID = 128,
    parameter int AWID = 32,
    parameter int TWID = 5,
    parameter int BWID = (DWID == 512) ? 6 : (DWID == 256) ? 5 :
                         (DWID == 128) ? 4 : (DWID == 64) ? 3 : 2,
    parameter int WID  = 2 + DWID + AWID + BWID + TWID
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            msg_vld,
    input  logic [WID-1:0]  msg,
    output logic            msg_rdy,
    output logic            wr_vld,
    input  logic            wr_rdy,
    output logic            rd_vld,
    input  logic            rd_rdy,
    output logic            rsp_vld,
    input  logic            rsp_rdy,
    output logic [DWID-1:0] out_data,
    output logic [AWID-1:0] out_addr,
    output logic [BWID-1:0] out_bytes,
    output logic [TWID-1:0] out_tag,
    output logic            err_dup,
    output logic            err_unexp,
    output logic [7:0]      err_cnt
);

    localparam int TAG_LO = 2;
    localparam int BYT_LO = TAG_LO + TWID;
    localparam int ADR_LO = BYT_LO + BWID;
    localparam int DAT_LO = ADR_LO + AWID;

    typedef enum logic [1:0] {
        CMD_NOP = 2'b00,
        CMD_WR  = 2'b01,
        CMD_RD  = 2'b10,
        CMD_RSP = 2'b11
    } cmd_e;

    logic [WID-1:0]       mem_q [2];
    logic                 wptr_q, rptr_q;
    logic [1:0]           cnt_q, cnt_d;
    logic [2**TWID-1:0]   sb_q;
    logic                 err_dup_q, err_unexp_q;
    logic                 err_dup_d, err_unexp_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic [WID-1:0]       head;
    logic                 head_vld;
    cmd_e                 head_cmd;
    logic [TWID-1:0]      head_tag;
    logic                 push, pop, sb_set, sb_clr;

    assign head     = mem_q[rptr_q];
    assign head_vld = !rst && (cnt_q != 2'd0);
    assign head_cmd = cmd_e'(head[1:0]);
    assign head_tag = head[BYT_LO-1:TAG_LO];

    assign msg_rdy  = !rst && (cnt_q != 2'd2);
    assign push     = msg_vld && msg_rdy;

    // Fields read zero whenever the FIFO holds nothing.
    assign out_data  = (cnt_q != 2'd0) ? head[WID-1:DAT_LO]    : '0;
    assign out_addr  = (cnt_q != 2'd0) ? head[DAT_LO-1:ADR_LO] : '0;
    assign out_bytes = (cnt_q != 2'd0) ? head[ADR_LO-1:BYT_LO] : '0;
    assign out_tag   = (cnt_q != 2'd0) ? head_tag              : '0;

    assign err_dup   = err_dup_q && !rst;
    assign err_unexp = err_unexp_q && !rst;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        wr_vld      = 1'b0;
        rd_vld      = 1'b0;
        rsp_vld     = 1'b0;
        pop         = 1'b0;
        sb_set      = 1'b0;
        sb_clr      = 1'b0;
        err_dup_d   = 1'b0;
        err_unexp_d = 1'b0;
        if (head_vld) begin
            case (head_cmd)
                CMD_NOP: pop = 1'b1;
                CMD_WR: begin
                    wr_vld = 1'b1;
                    pop    = wr_rdy;
                end
                CMD_RD: begin
                    rd_vld = 1'b1;
                    if (rd_rdy) begin
                        pop       = 1'b1;
                        sb_set    = 1'b1;
                        err_dup_d = sb_q[head_tag];
                    end
                end
                CMD_RSP: begin
                    // A response for a tag nobody is waiting on is dropped here.
                    if (sb_q[head_tag]) begin
                        rsp_vld = 1'b1;
                        if (rsp_rdy) begin
                            pop    = 1'b1;
                            sb_clr = 1'b1;
                        end
                    end else begin
                        pop         = 1'b1;
                        err_unexp_d = 1'b1;
                    end
                end
                default: pop = 1'b1;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        err_cnt_d = err_cnt_q;
        if ((err_dup_d || err_unexp_d) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= msg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            cnt_q       <= 2'd0;
            sb_q        <= '0;
            err_dup_q   <= 1'b0;
            err_unexp_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            if (push)
                wptr_q <= ~wptr_q;
            if (pop)
                rptr_q <= ~rptr_q;
            cnt_q <= cnt_d;
            if (sb_set)
                sb_q[head_tag] <= 1'b1;
            else if (sb_clr)
                sb_q[head_tag] <= 1'b0;
            err_dup_q   <= err_dup_d;
            err_unexp_q <= err_unexp_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_rou_msg_parse.sv
// Scoreboard bench for rou_msg_parse: message-level reference model fed at
// acceptance time, independent monitor checking handshakes and error pulses.
module tb_rou_msg_parse;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int TW = 5;
    localparam int BW = 4;
    localparam int W  = 2 + DW + AW + BW + TW;

    logic          clk = 1'b0;
    logic          rst;
    logic          msg_vld;
    logic [W-1:0]  msg;
    logic          msg_rdy;
    logic          wr_vld, wr_rdy, rd_vld, rd_rdy, rsp_vld, rsp_rdy;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [BW-1:0] out_bytes;
    logic [TW-1:0] out_tag;
    logic          err_dup, err_unexp;
    logic [7:0]    err_cnt;

    rou_msg_parse #(.DWID(DW), .AWID(AW), .TWID(TW)) dut (
        .clk(clk), .rst(rst), .msg_vld(msg_vld), .msg(msg), .msg_rdy(msg_rdy),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .out_data(out_data),
        .out_addr(out_addr), .out_bytes(out_bytes), .out_tag(out_tag),
        .err_dup(err_dup), .err_unexp(err_unexp), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   chan;   // 1 write, 2 read, 3 response
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [BW-1:0] bytes;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        int unsigned typ;      // 1 duplicate, 2 unexpected
        int unsigned cnt;
    } err_t;

    exp_t        exp_q[$];
    err_t        err_q[$];
    bit          m_sb [32];
    int unsigned m_cnt;
    int unsigned n_chk = 0, n_pass = 0;
    int unsigned wr_hs = 0;
    int unsigned rdy_mode = 1;  // 0 random, 1 all ready, 2 writes stalled

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [W-1:0] pack(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                          input logic [BW-1:0] b, input logic [TW-1:0] t,
                                          input logic [1:0] c);
        return {d, a, b, t, c};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        err_q.delete();
        for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_error(input int unsigned typ);
        err_t e;
        if (m_cnt < 255) m_cnt++;
        e.typ = typ;
        e.cnt = m_cnt;
        err_q.push_back(e);
    endtask

    // Outcome of each message follows from FIFO order alone.
    task automatic model_accept(input logic [W-1:0] m);
        exp_t e;
        logic [1:0] c;
        {e.data, e.addr, e.bytes, e.tag, c} = m;
        case (c)
            2'b01: begin e.chan = 1; exp_q.push_back(e); end
            2'b10: begin
                e.chan = 2;
                exp_q.push_back(e);
                if (m_sb[e.tag]) model_error(1);
                m_sb[e.tag] = 1'b1;
            end
            2'b11: begin
                if (m_sb[e.tag]) begin
                    e.chan = 3;
                    exp_q.push_back(e);
                    m_sb[e.tag] = 1'b0;
                end else model_error(2);
            end
            default: ;
        endcase
    endtask

    task automatic send(input logic [W-1:0] m);
        bit done = 0;
        msg_vld = 1'b1;
        msg     = m;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (msg_rdy) begin
                model_accept(m);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        msg_vld = 1'b0;
        if (!done) begin
            n_chk++;
            $display("FAIL send_timeout: message not accepted in 300 cycles");
        end
    endtask

    task automatic send_rand(input int unsigned cmd, input int unsigned tag);
        send(pack({$urandom, $urandom, $urandom, $urandom}, $urandom,
                  BW'($urandom), TW'(tag), 2'(cmd)));
    endtask

    task automatic drain();
        int unsigned i = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && i < 1000) begin
            @(posedge clk);
            i++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0 || err_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d outputs and %0d errors outstanding, expected 0",
                     exp_q.size(), err_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        msg_vld = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_outputs", {msg_rdy, wr_vld, rd_vld, rsp_vld, err_dup, err_unexp}, 6'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_state", {msg_rdy, wr_vld, rd_vld, rsp_vld, err_cnt}, {4'b1000, 8'd0});
        chk("post_rst_fields", {out_data, out_addr, out_bytes, out_tag}, '0);
        @(posedge clk);
        #1;
    endtask

    // Ready driver
    initial begin
        wr_rdy = 1'b1; rd_rdy = 1'b1; rsp_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: begin
                    wr_rdy  = ($urandom_range(0, 3) != 0);
                    rd_rdy  = ($urandom_range(0, 3) != 0);
                    rsp_rdy = ($urandom_range(0, 3) != 0);
                end
                2: begin wr_rdy = 1'b0; rd_rdy = 1'b1; rsp_rdy = 1'b1; end
                default: begin wr_rdy = 1'b1; rd_rdy = 1'b1; rsp_rdy = 1'b1; end
            endcase
        end
    end

    // Monitor
    initial begin
        exp_t e;
        err_t r;
        bit pend = 0;
        logic [2:0] pv;
        logic [168:0] pf;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
            end else begin
                if (pend)
                    chk("vld_stable", {wr_vld, rd_vld, rsp_vld, out_data, out_addr, out_bytes, out_tag},
                        {pv, pf});
                if (wr_vld || rd_vld || rsp_vld)
                    chk("vld_onehot", 32'(wr_vld) + 32'(rd_vld) + 32'(rsp_vld), 1);
                if ((wr_vld && wr_rdy) || (rd_vld && rd_rdy) || (rsp_vld && rsp_rdy)) begin
                    if (wr_vld) wr_hs++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL hs_extra: got handshake vld=%b expected none", {wr_vld, rd_vld, rsp_vld});
                    end else begin
                        e = exp_q.pop_front();
                        chk("hs_chan", wr_vld ? 1 : rd_vld ? 2 : 3, e.chan);
                        chk("hs_fields", {out_data, out_addr, out_bytes, out_tag},
                            {e.data, e.addr, e.bytes, e.tag});
                    end
                end
                pend = (wr_vld && !wr_rdy) || (rd_vld && !rd_rdy) || (rsp_vld && !rsp_rdy);
                pv = {wr_vld, rd_vld, rsp_vld};
                pf = {out_data, out_addr, out_bytes, out_tag};
                if (err_dup || err_unexp) begin
                    if (err_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL err_extra: got dup=%b unexp=%b expected none", err_dup, err_unexp);
                    end else begin
                        r = err_q.pop_front();
                        chk("err_type", {err_dup, err_unexp}, (r.typ == 1) ? 2'b10 : 2'b01);
                        chk("err_cnt", err_cnt, r.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int unsigned hs0;
        rst = 1'b1; msg_vld = 1'b0; msg = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_rst_outputs", {msg_rdy, wr_vld, rd_vld, rsp_vld, err_dup, err_unexp}, 6'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {msg_rdy, wr_vld, rd_vld, rsp_vld, err_cnt}, {4'b1000, 8'd0});
        chk("reset_fields", {out_data, out_addr, out_bytes, out_tag}, '0);
        @(posedge clk);
        #1;

        // First write appears the cycle after acceptance with exact fields
        send(pack({16{8'hA5}}, 32'h100, 4'd4, 5'd3, 2'b01));
        @(negedge clk);
        chk("lat_wr_vld", {wr_vld, msg_rdy}, 2'b11);
        chk("lat_fields", {out_data, out_addr, out_bytes, out_tag},
            {{16{8'hA5}}, 32'h100, 4'd4, 5'd3});
        @(posedge clk);
        #1;

        send_rand(2, 7);
        send_rand(3, 7);
        send_rand(3, 7);   // tag 7 retired, so this one is unexpected
        send_rand(3, 9);
        drain();
        chk("err_cnt_two", err_cnt, 8'd2);

        send_rand(2, 2);
        send_rand(2, 2);
        drain();

        // Stalled writes fill the FIFO, then drain in order on release
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_rand(1, 0);
        send_rand(1, 1);
        @(negedge clk);
        chk("full_rdy", msg_rdy, 1'b0);
        @(posedge clk);
        #1;
        fork
            send_rand(1, 2);
            begin
                repeat (5) @(posedge clk);
                #1;
                rdy_mode = 1;
            end
        join
        drain();

        hs0 = wr_hs;
        send_rand(1, 4);
        send_rand(0, 4);
        send_rand(1, 5);
        drain();
        chk("nop_wr_hs", wr_hs - hs0, 2);

        rdy_mode = 0;
        for (int i = 0; i < 150; i++)
            send_rand($urandom_range(0, 3), $urandom_range(0, 3));
        do_reset();
        for (int t = 0; t < 4; t++) send_rand(3, t);
        for (int i = 0; i < 150; i++)
            send_rand($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                                                        : $urandom_range(0, 3));
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 270; i++) send_rand(3, 20);
        drain();
        chk("err_cnt_sat", err_cnt, 8'd255);

        do_reset();
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
